// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-master Wishbone round-robin arbiter:
// FSM state encoding, master index constants and default values for the
// ACK-timeout configuration.
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Bit positions of each master inside the one-hot grant vector
    localparam int M0 = 0;
    localparam int M1 = 1;

    localparam int unsigned  CNTR_WIDTH_DEF         = 3;
    localparam int unsigned  CNTR_TIMEOUT_DEF       = 7;
    localparam logic [31:0]  DEFAULT_READ_VALUE_DEF = 32'hBADF_ABAC;

endpackage

// File: rtl/wb_arb_timeout_cnt.sv
// ---------------------------------------------------------------------------
// wb_arb_timeout_cnt
// Saturating cycle counter used to detect a slave that never acknowledges.
// Ports:
//   i_clk  clock
//   i_rst  asynchronous active-high reset
//   i_clr  synchronous clear (highest priority after reset)
//   i_en   count enable; the count holds once it reaches CNTR_TIMEOUT
//   o_hit  high while the count equals CNTR_TIMEOUT
// ---------------------------------------------------------------------------
module wb_arb_timeout_cnt
    import wb_arb_pkg::*;
#(
    parameter int unsigned CNTR_WIDTH   = CNTR_WIDTH_DEF,
    parameter int unsigned CNTR_TIMEOUT = CNTR_TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam logic [CNTR_WIDTH-1:0] L_LIMIT = CNTR_WIDTH'(CNTR_TIMEOUT);

    logic [CNTR_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != L_LIMIT)) begin
            // Stops at the limit so it can never wrap back to zero
            r_cnt <= r_cnt + CNTR_WIDTH'(1);
        end
    end

    assign o_hit = (r_cnt == L_LIMIT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Two-master round-robin arbiter for a single classic Wishbone slave path.
// Master 0 is the AHB-to-FPGA bridge, master 1 a local fabric master.
// One single transfer per grant; the arbiter re-arbitrates after every ACK,
// so two continuously requesting masters alternate.
//
// Optional feature (compile macro WBARB_TIMEOUT_EN): ACK timeout. After
// CNTR_TIMEOUT XFER cycles without s_ACK the granted master receives a
// forced ACK with DEFAULT_READ_VALUE, and to_err pulses for one cycle.
// Without the macro the arbiter waits indefinitely and to_err is 0.
//
// Ports:
//   WB_CLK, WB_RST                 clock, asynchronous active-high reset
//   mN_ADR/CYC/STB/WE/BYTE_STB/WR_DAT  master N request side (N = 0,1)
//   mN_RD_DAT, mN_ACK              read data / acknowledge to master N
//   s_ADR/CYC/STB/WE/BYTE_STB/WR_DAT   muxed request to the slave
//   s_RD_DAT, s_ACK                slave response
//   gnt                            one-hot current grant (00 = none)
//   to_err                         one-cycle pulse on a forced ACK
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned           ADDRWIDTH          = 17,
    parameter int unsigned           DATAWIDTH          = 32,
    parameter int unsigned           CNTR_WIDTH         = CNTR_WIDTH_DEF,
    parameter int unsigned           CNTR_TIMEOUT       = CNTR_TIMEOUT_DEF,
    parameter logic [DATAWIDTH-1:0]  DEFAULT_READ_VALUE = DATAWIDTH'(DEFAULT_READ_VALUE_DEF)
) (
    input  logic                     WB_CLK,
    input  logic                     WB_RST,
    input  logic [ADDRWIDTH-1:0]     m0_ADR,
    input  logic                     m0_CYC,
    input  logic                     m0_STB,
    input  logic                     m0_WE,
    input  logic [DATAWIDTH/8-1:0]   m0_BYTE_STB,
    input  logic [DATAWIDTH-1:0]     m0_WR_DAT,
    output logic [DATAWIDTH-1:0]     m0_RD_DAT,
    output logic                     m0_ACK,
    input  logic [ADDRWIDTH-1:0]     m1_ADR,
    input  logic                     m1_CYC,
    input  logic                     m1_STB,
    input  logic                     m1_WE,
    input  logic [DATAWIDTH/8-1:0]   m1_BYTE_STB,
    input  logic [DATAWIDTH-1:0]     m1_WR_DAT,
    output logic [DATAWIDTH-1:0]     m1_RD_DAT,
    output logic                     m1_ACK,
    output logic [ADDRWIDTH-1:0]     s_ADR,
    output logic                     s_CYC,
    output logic                     s_STB,
    output logic                     s_WE,
    output logic [DATAWIDTH/8-1:0]   s_BYTE_STB,
    output logic [DATAWIDTH-1:0]     s_WR_DAT,
    input  logic [DATAWIDTH-1:0]     s_RD_DAT,
    input  logic                     s_ACK,
    output logic [1:0]               gnt,
    output logic                     to_err
);

    // Reject a timeout that the counter could never reach
    if (CNTR_TIMEOUT > (2**CNTR_WIDTH) - 1) begin : g_bad_timeout_cfg
        $error("wb_rr_arbiter: CNTR_TIMEOUT does not fit in CNTR_WIDTH bits");
    end

    arb_state_t r_state;
    logic [1:0] r_gnt;
    logic       r_last;     // index of the master granted most recently

    logic w_req0, w_req1;
    logic w_xfer, w_sel0, w_sel1;
    logic w_gcyc, w_gstb;
    logic w_to_hit, w_to_ack;
    logic [DATAWIDTH-1:0] w_rd_dat;

    assign w_req0 = m0_CYC & m0_STB;
    assign w_req1 = m1_CYC & m1_STB;

    // Grant is only ever nonzero in XFER, but gating by state keeps every
    // slave-side and master-side output at zero the instant reset asserts.
    assign w_xfer = (r_state == XFER);
    assign w_sel0 = w_xfer & r_gnt[M0];
    assign w_sel1 = w_xfer & r_gnt[M1];

    assign w_gcyc = (w_sel0 & m0_CYC) | (w_sel1 & m1_CYC);
    assign w_gstb = (w_sel0 & m0_STB) | (w_sel1 & m1_STB);

`ifdef WBARB_TIMEOUT_EN
    wb_arb_timeout_cnt #(
        .CNTR_WIDTH   (CNTR_WIDTH),
        .CNTR_TIMEOUT (CNTR_TIMEOUT)
    ) u_to_cnt (
        .i_clk (WB_CLK),
        .i_rst (WB_RST),
        .i_clr (~w_xfer),
        .i_en  (w_xfer & ~s_ACK),
        .o_hit (w_to_hit)
    );
`else
    assign w_to_hit = 1'b0;
`endif

    // A real slave ACK in the timeout cycle wins; an aborted cycle never times out
    assign w_to_ack = w_to_hit & w_gcyc & ~s_ACK;
    assign to_err   = w_to_ack;

    assign s_CYC      = w_gcyc;
    assign s_STB      = w_gstb & ~w_to_hit;
    assign s_ADR      = w_sel1 ? m1_ADR      : (w_sel0 ? m0_ADR      : '0);
    assign s_WE       = w_sel1 ? m1_WE       : (w_sel0 ? m0_WE       : 1'b0);
    assign s_BYTE_STB = w_sel1 ? m1_BYTE_STB : (w_sel0 ? m0_BYTE_STB : '0);
    assign s_WR_DAT   = w_sel1 ? m1_WR_DAT   : (w_sel0 ? m0_WR_DAT   : '0);

    assign w_rd_dat  = w_to_ack ? DEFAULT_READ_VALUE : s_RD_DAT;
    assign m0_RD_DAT = w_sel0 ? w_rd_dat : '0;
    assign m1_RD_DAT = w_sel1 ? w_rd_dat : '0;
    assign m0_ACK    = w_sel0 & (s_ACK | w_to_ack);
    assign m1_ACK    = w_sel1 & (s_ACK | w_to_ack);

    assign gnt = r_gnt;

    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_state <= XFER;
                        // On a tie the master that did not win last time goes next
                        if (w_req0 && (!w_req1 || r_last)) begin
                            r_gnt  <= 2'b01;
                            r_last <= 1'b0;
                        end else begin
                            r_gnt  <= 2'b10;
                            r_last <= 1'b1;
                        end
                    end
                end
                XFER: begin
                    // Done on slave ACK, forced ACK, or master abort (CYC dropped)
                    if (!w_gcyc || s_ACK || w_to_ack) begin
                        r_state <= IDLE;
                        r_gnt   <= 2'b00;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    logic        WB_CLK = 1'b0;
    logic        WB_RST;
    logic [16:0] m0_ADR, m1_ADR, s_ADR;
    logic        m0_CYC, m0_STB, m0_WE, m1_CYC, m1_STB, m1_WE;
    logic [3:0]  m0_BYTE_STB, m1_BYTE_STB, s_BYTE_STB;
    logic [31:0] m0_WR_DAT, m1_WR_DAT, m0_RD_DAT, m1_RD_DAT, s_WR_DAT, s_RD_DAT;
    logic        m0_ACK, m1_ACK, s_CYC, s_STB, s_WE, s_ACK, to_err;
    logic [1:0]  gnt;

    int n_vec = 0;
    int n_err = 0;

    wb_rr_arbiter dut (
        .WB_CLK      (WB_CLK),
        .WB_RST      (WB_RST),
        .m0_ADR      (m0_ADR),
        .m0_CYC      (m0_CYC),
        .m0_STB      (m0_STB),
        .m0_WE       (m0_WE),
        .m0_BYTE_STB (m0_BYTE_STB),
        .m0_WR_DAT   (m0_WR_DAT),
        .m0_RD_DAT   (m0_RD_DAT),
        .m0_ACK      (m0_ACK),
        .m1_ADR      (m1_ADR),
        .m1_CYC      (m1_CYC),
        .m1_STB      (m1_STB),
        .m1_WE       (m1_WE),
        .m1_BYTE_STB (m1_BYTE_STB),
        .m1_WR_DAT   (m1_WR_DAT),
        .m1_RD_DAT   (m1_RD_DAT),
        .m1_ACK      (m1_ACK),
        .s_ADR       (s_ADR),
        .s_CYC       (s_CYC),
        .s_STB       (s_STB),
        .s_WE        (s_WE),
        .s_BYTE_STB  (s_BYTE_STB),
        .s_WR_DAT    (s_WR_DAT),
        .s_RD_DAT    (s_RD_DAT),
        .s_ACK       (s_ACK),
        .gnt         (gnt),
        .to_err      (to_err)
    );

    always #5 WB_CLK = ~WB_CLK;

    task automatic step();
        @(posedge WB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet_masters();
        m0_ADR = '0; m0_CYC = 0; m0_STB = 0; m0_WE = 0; m0_BYTE_STB = '0; m0_WR_DAT = '0;
        m1_ADR = '0; m1_CYC = 0; m1_STB = 0; m1_WE = 0; m1_BYTE_STB = '0; m1_WR_DAT = '0;
        s_ACK = 0; s_RD_DAT = '0;
    endtask

    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        // ---- reset state ----
        WB_RST = 1'b1;
        quiet_masters();
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_s_cyc", 32'(s_CYC), 32'h0);
        chk("rst_m0_ack", 32'(m0_ACK), 32'h0);
        chk("rst_to_err", 32'(to_err), 32'h0);
        step(); step();
        WB_RST = 1'b0;
        step();

        // ---- m0 single read, slave ACKs in second XFER cycle ----
        m0_ADR = 17'h00014; m0_WE = 0; m0_BYTE_STB = 4'hF; m0_CYC = 1; m0_STB = 1;
        #1;
        chk("rd_pre_gnt", 32'(gnt), 32'h0);
        chk("rd_pre_stb", 32'(s_STB), 32'h0);
        step();
        chk("rd_gnt", 32'(gnt), 32'h1);
        chk("rd_s_stb", 32'(s_STB), 32'h1);
        chk("rd_s_adr", 32'(s_ADR), 32'h14);
        chk("rd_s_we", 32'(s_WE), 32'h0);
        chk("rd_ack_wait", 32'(m0_ACK), 32'h0);
        step();
        s_ACK = 1; s_RD_DAT = 32'h0000_00A5;
        #1;
        chk("rd_m0_ack", 32'(m0_ACK), 32'h1);
        chk("rd_m0_dat", m0_RD_DAT, 32'h0000_00A5);
        chk("rd_m1_ack", 32'(m1_ACK), 32'h0);
        chk("rd_m1_dat", m1_RD_DAT, 32'h0);
        step();
        s_ACK = 0; m0_CYC = 0; m0_STB = 0;
        #1;
        chk("rd_gnt_after", 32'(gnt), 32'h0);
        chk("rd_ack_after", 32'(m0_ACK), 32'h0);

        // ---- asynchronous reset in the middle of a transfer ----
        m0_CYC = 1; m0_STB = 1;
        step();
        chk("ar_gnt_pre", 32'(gnt), 32'h1);
        chk("ar_cyc_pre", 32'(s_CYC), 32'h1);
        #1;
        WB_RST = 1; s_ACK = 1;
        #1;
        chk("ar_gnt", 32'(gnt), 32'h0);
        chk("ar_s_cyc", 32'(s_CYC), 32'h0);
        chk("ar_s_stb", 32'(s_STB), 32'h0);
        chk("ar_m0_ack", 32'(m0_ACK), 32'h0);
        chk("ar_m1_ack", 32'(m1_ACK), 32'h0);
        quiet_masters();
        step();
        WB_RST = 0;
        step();

        // ---- simultaneous requests after reset alternate m0,m1,m0,m1 ----
        m0_ADR = 17'h00100; m0_CYC = 1; m0_STB = 1;
        m1_ADR = 17'h00200; m1_CYC = 1; m1_STB = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(exp_g[i]));
            s_ACK = 1;
            #1;
            chk("rr_m0_ack", 32'(m0_ACK), 32'(exp_g[i][0]));
            chk("rr_m1_ack", 32'(m1_ACK), 32'(exp_g[i][1]));
            step();
            s_ACK = 0;
            #1;
            chk("rr_idle", 32'(gnt), 32'h0);
        end
        quiet_masters();
        step();

        // ---- m1 write, m0 shows junk without CYC ----
        m0_ADR = 17'h1FFFF; m0_WR_DAT = 32'hFFFF_FFFF; m0_BYTE_STB = 4'hF; m0_STB = 1;
        m1_ADR = 17'h0000C; m1_BYTE_STB = 4'h3; m1_WR_DAT = 32'h1234_5678; m1_WE = 1;
        m1_CYC = 1; m1_STB = 1;
        step();
        chk("wr_gnt", 32'(gnt), 32'h2);
        chk("wr_s_adr", 32'(s_ADR), 32'h0000C);
        chk("wr_s_bstb", 32'(s_BYTE_STB), 32'h3);
        chk("wr_s_dat", s_WR_DAT, 32'h1234_5678);
        chk("wr_s_we", 32'(s_WE), 32'h1);
        chk("wr_s_cyc", 32'(s_CYC), 32'h1);
        s_ACK = 1;
        #1;
        chk("wr_m1_ack", 32'(m1_ACK), 32'h1);
        chk("wr_m0_ack", 32'(m0_ACK), 32'h0);
        step();
        quiet_masters();
        step();

        // ---- m1 aborts after one XFER cycle, pending m0 then granted ----
        m1_ADR = 17'h00033; m1_CYC = 1; m1_STB = 1;
        step();
        chk("ab_gnt_m1", 32'(gnt), 32'h2);
        step();
        m0_ADR = 17'h00044; m0_CYC = 1; m0_STB = 1;
        m1_CYC = 0; m1_STB = 0;
        #1;
        chk("ab_s_cyc", 32'(s_CYC), 32'h0);
        chk("ab_m1_ack", 32'(m1_ACK), 32'h0);
        chk("ab_m0_ack", 32'(m0_ACK), 32'h0);
        step();
        chk("ab_idle", 32'(gnt), 32'h0);
        step();
        chk("ab_gnt_m0", 32'(gnt), 32'h1);
        chk("ab_s_adr", 32'(s_ADR), 32'h00044);
        s_ACK = 1;
        #1;
        chk("ab_m0_done", 32'(m0_ACK), 32'h1);
        step();
        quiet_masters();
        step();

`ifdef WBARB_TIMEOUT_EN
        // ---- silent slave: forced ACK in the eighth XFER cycle ----
        m0_ADR = 17'h00055; m0_CYC = 1; m0_STB = 1;
        step();
        for (int k = 1; k <= 7; k++) begin
            chk("to_wait_ack", 32'(m0_ACK), 32'h0);
            chk("to_wait_err", 32'(to_err), 32'h0);
            step();
        end
        chk("to_m0_ack", 32'(m0_ACK), 32'h1);
        chk("to_m0_dat", m0_RD_DAT, 32'hBADF_ABAC);
        chk("to_err", 32'(to_err), 32'h1);
        chk("to_s_stb", 32'(s_STB), 32'h0);
        step();
        chk("to_err_pulse", 32'(to_err), 32'h0);
        chk("to_idle", 32'(gnt), 32'h0);
        // same again, but the slave answers in the timeout cycle
        step();
        chk("to2_gnt", 32'(gnt), 32'h1);
        for (int k = 1; k <= 7; k++) step();
        s_ACK = 1; s_RD_DAT = 32'h0000_005A;
        #1;
        chk("to2_m0_ack", 32'(m0_ACK), 32'h1);
        chk("to2_m0_dat", m0_RD_DAT, 32'h0000_005A);
        chk("to2_err", 32'(to_err), 32'h0);
        step();
        quiet_masters();
        step();
`else
        // ---- silent slave: no timeout, arbiter keeps waiting ----
        m0_ADR = 17'h00055; m0_CYC = 1; m0_STB = 1;
        step();
        for (int k = 1; k <= 10; k++) begin
            chk("nto_ack", 32'(m0_ACK), 32'h0);
            chk("nto_err", 32'(to_err), 32'h0);
            chk("nto_gnt", 32'(gnt), 32'h1);
            step();
        end
        m0_CYC = 0; m0_STB = 0;
        step();
        chk("nto_abort", 32'(gnt), 32'h0);
        quiet_masters();
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
